// File: rtl/alu_move_controller_if.sv
// Bundle between the path-search requester / ALU datapath (master) and the move controller (slave).
interface alu_move_controller_if #(
    parameter int size = 5
);
    logic            start;
    logic [1:0]      dir;
    logic [size:0]   alu_res;
    logic            alu_sign;
    logic [size-1:0] alu_in1;
    logic [size-1:0] alu_in2;
    logic            alu_op;
    logic            alu_iseq;
    logic [size-1:0] x;
    logic [size-1:0] y;
    logic            busy;
    logic            done;
    logic            blocked;
    logic [7:0]      move_count;

    modport master (
        output start, dir, alu_res, alu_sign,
        input  alu_in1, alu_in2, alu_op, alu_iseq, x, y, busy, done, blocked, move_count
    );

    modport slave (
        input  start, dir, alu_res, alu_sign,
        output alu_in1, alu_in2, alu_op, alu_iseq, x, y, busy, done, blocked, move_count
    );
endinterface

// File: rtl/alu_move_controller.sv
// Steps an (x, y) coordinate by +/-5 through the shared ALU, range-checks the result, commits or blocks.
// Latency: start at edge N -> x/y updated at N+2, done pulse in the following cycle, idle again from N+3.
// Backpressure: none; start is only sampled in IDLE and dropped while busy. MOVE_COUNT_EN enables move_count.
module alu_move_controller #(
    parameter int size      = 5,
    parameter int MAX_COORD = 31,
    parameter int INIT_X    = 0,
    parameter int INIT_Y    = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    alu_move_controller_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [size-1:0] MAX_C   = size'(MAX_COORD);
    localparam logic [size-1:0] INIT_XC = size'(INIT_X);
    localparam logic [size-1:0] INIT_YC = size'(INIT_Y);

    state_t          state_q;
    logic [size:0]   res_q;
    logic            sign_q;
    logic [size-1:0] x_q, x_d;
    logic [size-1:0] y_q, y_d;
    logic            blocked_q, blocked_d;
    logic            op_q;
    logic            iseq_q;
    logic            done_q;
    logic            invalid;

`ifdef MOVE_COUNT_EN
    logic [7:0]      cnt_q, cnt_d;
`endif

    // res_q[size] is the add-overflow bit; it blocks the move exactly like a negative result.
    assign invalid = sign_q | res_q[size] | (res_q[size-1:0] > MAX_C);

    always_comb begin
        x_d       = x_q;
        y_d       = y_q;
        blocked_d = blocked_q;
`ifdef MOVE_COUNT_EN
        cnt_d     = cnt_q;
`endif
        if (state_q == CHECK) begin
            blocked_d = invalid;
            if (!invalid) begin
                // iseq_q is the latched dir[1]: it picks the axis the ALU worked on.
                if (iseq_q) begin
                    y_d = res_q[size-1:0];
                end else begin
                    x_d = res_q[size-1:0];
                end
`ifdef MOVE_COUNT_EN
                if (cnt_q != 8'hFF) begin
                    cnt_d = cnt_q + 8'd1;
                end
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= IDLE;
            res_q     <= '0;
            sign_q    <= 1'b0;
            x_q       <= INIT_XC;
            y_q       <= INIT_YC;
            blocked_q <= 1'b0;
            op_q      <= 1'b0;
            iseq_q    <= 1'b0;
            done_q    <= 1'b0;
`ifdef MOVE_COUNT_EN
            cnt_q     <= 8'd0;
`endif
        end else begin
            x_q       <= x_d;
            y_q       <= y_d;
            blocked_q <= blocked_d;
            done_q    <= 1'b0;
`ifdef MOVE_COUNT_EN
            cnt_q     <= cnt_d;
`endif
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        // ALU controls are registered here so they are valid throughout CALC.
                        op_q    <= ~bus.dir[0];
                        iseq_q  <= bus.dir[1];
                        state_q <= CALC;
                    end
                end
                CALC: begin
                    res_q   <= bus.alu_res;
                    sign_q  <= bus.alu_sign;
                    state_q <= CHECK;
                end
                CHECK: begin
                    done_q  <= 1'b1;
                    state_q <= DONE;
                end
                DONE: begin
                    op_q    <= 1'b0;
                    iseq_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.alu_in1  = x_q;
    assign bus.alu_in2  = y_q;
    assign bus.alu_op   = op_q;
    assign bus.alu_iseq = iseq_q;
    assign bus.x        = x_q;
    assign bus.y        = y_q;
    assign bus.busy     = (state_q != IDLE);
    assign bus.done     = done_q;
    assign bus.blocked  = blocked_q;
`ifdef MOVE_COUNT_EN
    assign bus.move_count = cnt_q;
`else
    assign bus.move_count = 8'd0;
`endif

endmodule

// File: doc/alu_move_controller.md
Name: alu_move_controller

Overview:
- Sequences the shared ±5 ALU to step a 2-D coordinate (x, y) in response to move requests.
- Holds the x/y position registers and drives the ALU operands and controls.
- Captures the ALU result and range-checks it; commits the move or flags it as blocked.
- Sits between the path-search FSM (the requester) and the ALU datapath.

Parameters:
- size, 5: coordinate width; the ALU result is size+1 bits.
- MAX_COORD, 31: largest legal coordinate value, inclusive.
- INIT_X, 0: x value loaded at reset.
- INIT_Y, 0: y value loaded at reset.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  reset; synchronous, active-low (0 = reset).
- start  input  1  move request; sampled only in IDLE.
- dir  input  2  direction: 00 = x+5, 01 = x-5, 10 = y+5, 11 = y-5.
- alu_res  input  size+1  result from the ALU.
- alu_sign  input  1  ALU result MSB.
- alu_in1  output  size  ALU operand 1, always equal to x.
- alu_in2  output  size  ALU operand 2, always equal to y.
- alu_op  output  1  0 = subtract 5, 1 = add 5.
- alu_iseq  output  1  0 = operate on in1 (x), 1 = operate on in2 (y).
- x  output  size  current x coordinate.
- y  output  size  current y coordinate.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse when a move completes.
- blocked  output  1  result of the last move; 1 = rejected; held until the next done.
- move_count  output  8  count of successful moves (see Optional Feature).

Behaviour:
- Reset (rst == 0 at a clock edge):
  - state = IDLE, x = INIT_X, y = INIT_Y.
  - done = 0, blocked = 0, busy = 0, move_count = 0, latched dir = 0, captured result = 0.
  - Reset overrides any in-progress move; no commit happens.
- States: IDLE -> CALC -> CHECK -> DONE -> IDLE.
- IDLE:
  - If start == 1, latch dir and go to CALC.
  - Otherwise stay in IDLE.
- CALC:
  - Drive alu_op = ~dir[0] and alu_iseq = dir[1].
  - The ALU is combinational; capture alu_res and alu_sign into an internal register at the end of the cycle.
  - Go to CHECK.
- CHECK:
  - invalid = captured sign OR (captured res[size-1:0] > MAX_COORD).
  - If valid, write res[size-1:0] into x (dir[1] == 0) or y (dir[1] == 1).
  - Set blocked = invalid. Go to DONE.
- DONE: done = 1 for exactly this cycle, then return to IDLE.
- Latency: start sampled at edge N; the new x/y are visible after edge N+2; done is high in the cycle after edge N+2, and busy is low again from edge N+3.
- Operand outputs:
  - alu_op and alu_iseq hold their CALC values through CHECK and DONE.
  - In IDLE they are 0.
- Boundary cases:
  - start while busy is ignored; it is not queued.
  - start held high continuously issues a new move on every IDLE cycle.
  - A subtract below 0 wraps to a negative value with sign = 1, so the move is blocked.
  - An add past 31 sets bit size; this is also treated as sign = 1 and blocked.
  - With MAX_COORD < 31, the compare on the low bits also blocks.
  - A blocked move leaves x and y unchanged.
- busy is a pure state decode: asserted in CALC, CHECK and DONE.

Optional Feature:
- Macro: MOVE_COUNT_EN.
- Defined:
  - move_count increments by 1 in CHECK when the move is valid.
  - It saturates at 255 and clears on reset.
- Undefined: the counter logic is omitted and move_count is tied to 0.

Test Plan:
- Reset then start with dir = 00, x = 0 -> alu_op = 1 and alu_iseq = 0 in CALC; done 3 cycles after start; x = 5, blocked = 0.
- x = 0, start with dir = 01 -> ALU returns 6'b111011 with sign = 1; blocked = 1, x stays 0.
- Seven moves with dir = 10 from y = 0 -> y steps 5, 10, ..., 30. The seventh move yields res = 35 (bit 5 set), so blocked = 1 and y stays 30. With MOVE_COUNT_EN, move_count = 6.
- Pulse start again during CALC and CHECK -> ignored; exactly one done pulse, and busy is high for 3 cycles.
- rst = 0 during CHECK of an x+5 move from x = 10 -> at the next edge x = INIT_X, state = IDLE, done never pulses.
- MAX_COORD = 20, x = 20, dir = 00 -> res = 25 exceeds the limit; blocked = 1, x stays 20.
